// File: rtl/multi_port_reservation_station.sv
// Reservation station with multi-port operand wake-up, same-cycle allocation bypass and
// oldest-ready issue. take and output both follow valid/ready: a transfer happens on a
// rising edge where valid and ready are both high; ready never depends on its own valid.
module multi_port_reservation_station #(
  parameter int  OPERANDS     = 2,
  parameter int  RS_OFFSET    = 0,
  parameter int  RS_DEPTH     = 8,
  parameter int  RS_ID_WIDTH  = 5,
  parameter int  UPDATE_PORTS = 2,
  parameter int  VALUE_WIDTH  = 32,
  parameter type CONTROL_TYPE = logic [7:0],
  localparam int OCC_W        = $clog2(RS_DEPTH + 1),
  localparam int IDX_W        = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    take_valid,
  output logic                                    take_ready,
  input  logic [OPERANDS-1:0]                     op_value_valid_in,
  input  logic [OPERANDS-1:0][RS_ID_WIDTH-1:0]    op_rs_id_in,
  input  logic [OPERANDS-1:0][VALUE_WIDTH-1:0]    op_value_in,
  input  CONTROL_TYPE                             control_in,
  output logic [RS_ID_WIDTH-1:0]                  id_taken,
  input  logic [UPDATE_PORTS-1:0]                 update_valid,
  input  logic [UPDATE_PORTS-1:0][RS_ID_WIDTH-1:0] update_rs_id_in,
  input  logic [UPDATE_PORTS-1:0][VALUE_WIDTH-1:0] update_value_in,
  input  logic                                    flush,
  output logic                                    output_valid,
  input  logic                                    output_ready,
  output logic [OPERANDS-1:0][VALUE_WIDTH-1:0]    op_value_out,
  output CONTROL_TYPE                             control_out,
  output logic [RS_ID_WIDTH-1:0]                  output_rs_id,
  output logic [OCC_W-1:0]                        occupancy
);

  logic [RS_DEPTH-1:0]                     busy_q, busy_d;
  logic [OPERANDS-1:0]                     vld_q [RS_DEPTH];
  logic [OPERANDS-1:0]                     vld_d [RS_DEPTH];
  logic [OPERANDS-1:0][VALUE_WIDTH-1:0]    val_q [RS_DEPTH];
  logic [OPERANDS-1:0][VALUE_WIDTH-1:0]    val_d [RS_DEPTH];
  logic [OPERANDS-1:0][RS_ID_WIDTH-1:0]    tag_q [RS_DEPTH];
  logic [OPERANDS-1:0][RS_ID_WIDTH-1:0]    tag_d [RS_DEPTH];
  CONTROL_TYPE                             ctrl_q [RS_DEPTH];
  CONTROL_TYPE                             ctrl_d [RS_DEPTH];
  // older_q[i][j] set means slot i was accepted before slot j
  logic [RS_DEPTH-1:0]                     older_q [RS_DEPTH];
  logic [RS_DEPTH-1:0]                     older_d [RS_DEPTH];
  logic [OCC_W-1:0]                        occ_q, occ_d;

  logic                 alloc_found;
  logic [IDX_W-1:0]     alloc_idx;
  logic [RS_DEPTH-1:0]  ready;
  logic [RS_DEPTH-1:0]  oldest;
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic                 take_fire;
  logic                 issue_fire;

  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    ready     = '0;
    oldest    = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready[i] = busy_q[i] && (&vld_q[i]);
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      oldest[i] = ready[i];
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (ready[j] && older_q[j][i]) oldest[i] = 1'b0;
      end
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (oldest[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign take_ready   = alloc_found && !flush;
  assign id_taken     = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(alloc_idx);
  assign output_valid = sel_found && !flush;
  assign op_value_out = output_valid ? val_q[sel_idx] : '0;
  assign control_out  = output_valid ? ctrl_q[sel_idx] : '0;
  assign output_rs_id = output_valid ? (RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(sel_idx)) : '0;
  assign occupancy    = occ_q;

  assign take_fire  = take_valid && take_ready;
  assign issue_fire = output_valid && output_ready;

  always_comb begin
    busy_d  = busy_q;
    vld_d   = vld_q;
    val_d   = val_q;
    tag_d   = tag_q;
    ctrl_d  = ctrl_q;
    older_d = older_q;
    occ_d   = occ_q + OCC_W'(take_fire) - OCC_W'(issue_fire);

    // Descending port scan so the lowest-indexed matching port has the final word.
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int o = 0; o < OPERANDS; o++) begin
        if (busy_q[i] && !vld_q[i][o]) begin
          for (int p = UPDATE_PORTS - 1; p >= 0; p--) begin
            if (update_valid[p] && (update_rs_id_in[p] == tag_q[i][o])) begin
              vld_d[i][o] = 1'b1;
              val_d[i][o] = update_value_in[p];
            end
          end
        end
      end
    end

    if (issue_fire) busy_d[sel_idx] = 1'b0;

    if (take_fire) begin
      busy_d[alloc_idx]  = 1'b1;
      ctrl_d[alloc_idx]  = control_in;
      tag_d[alloc_idx]   = op_rs_id_in;
      older_d[alloc_idx] = '0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (IDX_W'(j) != alloc_idx) older_d[j][alloc_idx] = 1'b1;
      end
      for (int o = 0; o < OPERANDS; o++) begin
        vld_d[alloc_idx][o] = op_value_valid_in[o];
        val_d[alloc_idx][o] = op_value_in[o];
        if (!op_value_valid_in[o]) begin
          for (int p = UPDATE_PORTS - 1; p >= 0; p--) begin
            if (update_valid[p] && (update_rs_id_in[p] == op_rs_id_in[o])) begin
              vld_d[alloc_idx][o] = 1'b1;
              val_d[alloc_idx][o] = update_value_in[p];
            end
          end
        end
      end
    end

    if (flush) begin
      busy_d = '0;
      occ_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        vld_q[i]   <= '0;
        val_q[i]   <= '0;
        tag_q[i]   <= '0;
        ctrl_q[i]  <= '0;
        older_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      occ_q   <= occ_d;
      vld_q   <= vld_d;
      val_q   <= val_d;
      tag_q   <= tag_d;
      ctrl_q  <= ctrl_d;
      older_q <= older_d;
    end
  end

endmodule

// File: tb/tb_multi_port_reservation_station.sv
// Bench for multi_port_reservation_station: directed scenarios plus random traffic checked
// against an age-ordered queue model of the station contents.
module tb_multi_port_reservation_station;

  localparam int DEPTH = 8;

  logic             clk;
  logic             rst;
  logic             take_valid;
  logic             take_ready;
  logic [1:0]       op_value_valid_in;
  logic [1:0][4:0]  op_rs_id_in;
  logic [1:0][31:0] op_value_in;
  logic [7:0]       control_in;
  logic [4:0]       id_taken;
  logic [1:0]       update_valid;
  logic [1:0][4:0]  update_rs_id_in;
  logic [1:0][31:0] update_value_in;
  logic             flush;
  logic             output_valid;
  logic             output_ready;
  logic [1:0][31:0] op_value_out;
  logic [7:0]       control_out;
  logic [4:0]       output_rs_id;
  logic [3:0]       occupancy;

  multi_port_reservation_station dut (
    .clk(clk), .rst(rst),
    .take_valid(take_valid), .take_ready(take_ready),
    .op_value_valid_in(op_value_valid_in), .op_rs_id_in(op_rs_id_in),
    .op_value_in(op_value_in), .control_in(control_in), .id_taken(id_taken),
    .update_valid(update_valid), .update_rs_id_in(update_rs_id_in),
    .update_value_in(update_value_in), .flush(flush),
    .output_valid(output_valid), .output_ready(output_ready),
    .op_value_out(op_value_out), .control_out(control_out),
    .output_rs_id(output_rs_id), .occupancy(occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]       tag;
    logic [1:0]       vld;
    logic [1:0][4:0]  src;
    logic [1:0][31:0] val;
    logic [7:0]       ctrl;
  } ent_t;

  ent_t        m_q[$];     // buffered instructions, oldest first
  logic [4:0]  exp_q[$];   // expected issue order for the fill/drain scenario
  int          checks;
  int          errors;
  int          sel;
  logic        exp_tr;
  logic        exp_ov;
  logic [4:0]  exp_id;
  logic [87:0] exp_b;
  logic [87:0] act_b;

  task automatic idle();
    take_valid        = 1'b0;
    op_value_valid_in = '0;
    op_rs_id_in       = '0;
    op_value_in       = '0;
    control_in        = '0;
    update_valid      = '0;
    update_rs_id_in   = '0;
    update_value_in   = '0;
    flush             = 1'b0;
    output_ready      = 1'b0;
  endtask

  // Predicts this cycle's outputs from the model and samples the DUT, mid-cycle.
  task automatic sample();
    bit   used [DEPTH];
    ent_t e;
    @(negedge clk);
    if (rst) m_q.delete();
    for (int t = 0; t < DEPTH; t++) used[t] = 1'b0;
    for (int k = 0; k < m_q.size(); k++) used[m_q[k].tag] = 1'b1;
    exp_id = 5'd0;
    for (int t = DEPTH - 1; t >= 0; t--) if (!used[t]) exp_id = 5'(t);
    exp_tr = (m_q.size() < DEPTH) && !flush;
    sel = -1;
    for (int k = m_q.size() - 1; k >= 0; k--) if (m_q[k].vld == 2'b11) sel = k;
    exp_ov = (sel >= 0) && !flush;
    if (exp_ov) begin
      e = m_q[sel];
      exp_b = {exp_tr, exp_id, 1'b1, e.tag, e.val, e.ctrl, 4'(m_q.size())};
    end else begin
      exp_b = {exp_tr, exp_id, 1'b0, 5'd0, 64'd0, 8'd0, 4'(m_q.size())};
    end
    act_b = {take_ready, id_taken, output_valid, output_rs_id, op_value_out, control_out, occupancy};
  endtask

  // Applies the cycle's handshakes to the model, then steps past the clock edge.
  task automatic advance();
    bit   tf;
    bit   isf;
    bit   hit;
    ent_t e;
    tf  = take_valid && exp_tr;
    isf = exp_ov && output_ready;
    if (rst || flush) begin
      m_q.delete();
    end else begin
      for (int k = 0; k < m_q.size(); k++) begin
        e = m_q[k];
        for (int o = 0; o < 2; o++) begin
          hit = 1'b0;
          for (int p = 0; p < 2; p++) begin
            if (!e.vld[o] && !hit && update_valid[p] && update_rs_id_in[p] == e.src[o]) begin
              hit = 1'b1;
              e.vld[o] = 1'b1;
              e.val[o] = update_value_in[p];
            end
          end
        end
        m_q[k] = e;
      end
      if (isf) m_q.delete(sel);
      if (tf) begin
        e      = '0;
        e.tag  = exp_id;
        e.ctrl = control_in;
        for (int o = 0; o < 2; o++) begin
          e.vld[o] = op_value_valid_in[o];
          e.val[o] = op_value_in[o];
          e.src[o] = op_rs_id_in[o];
          hit = 1'b0;
          for (int p = 0; p < 2; p++) begin
            if (!e.vld[o] && !hit && update_valid[p] && update_rs_id_in[p] == op_rs_id_in[o]) begin
              hit = 1'b1;
              e.vld[o] = 1'b1;
              e.val[o] = update_value_in[p];
            end
          end
        end
        m_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    sample();
    checks++;
    if (act_b !== exp_b) begin
      errors++; $display("FAIL reset_model act=%h exp=%h", act_b, exp_b);
    end
    checks++;
    if ({take_ready, id_taken, occupancy, output_valid, output_rs_id, op_value_out, control_out}
        !== {1'b1, 5'd0, 4'd0, 1'b0, 5'd0, 64'd0, 8'd0}) begin
      errors++; $display("FAIL reset_values tr=%b id=%0d occ=%0d ov=%b rid=%0d val=%h ctrl=%h",
                          take_ready, id_taken, occupancy, output_valid, output_rs_id, op_value_out, control_out);
    end
    advance();
    rst = 1'b0;
    sample();
    checks++;
    if ({take_ready, id_taken, occupancy, output_valid} !== {1'b1, 5'd0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL idle_after_reset tr=%b id=%0d occ=%0d ov=%b required 1 0 0 0",
                          take_ready, id_taken, occupancy, output_valid);
    end
    advance();
  endtask

  task automatic test_fill_drain();
    logic [4:0] t;
    idle();
    for (int i = 0; i < 10; i++) begin
      take_valid        = 1'b1;
      op_value_valid_in = 2'b11;
      op_value_in[0]    = 32'(i);
      op_value_in[1]    = 32'(i + 1);
      control_in        = 8'(100 + i);
      sample();
      checks++;
      if (act_b !== exp_b) begin
        errors++; $display("FAIL fill_model i=%0d act=%h exp=%h", i, act_b, exp_b);
      end
      checks++;
      if (take_ready !== (i < 8)) begin
        errors++; $display("FAIL fill_take_ready i=%0d act=%b", i, take_ready);
      end
      if (i < 8) begin
        checks++;
        if (id_taken !== 5'(i)) begin
          errors++; $display("FAIL fill_id i=%0d act=%0d exp=%0d", i, id_taken, i);
        end
        exp_q.push_back(5'(i));
      end
      advance();
    end
    take_valid = 1'b0;
    sample();
    checks++;
    if (occupancy !== 4'd8 || take_ready !== 1'b0) begin
      errors++; $display("FAIL full_state occ=%0d tr=%b required 8 0", occupancy, take_ready);
    end
    advance();
    output_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample();
      checks++;
      if (act_b !== exp_b) begin
        errors++; $display("FAIL drain_model i=%0d act=%h exp=%h", i, act_b, exp_b);
      end
      t = exp_q.pop_front();
      checks++;
      if (output_valid !== 1'b1 || output_rs_id !== t || op_value_out !== {32'(i + 1), 32'(i)}) begin
        errors++; $display("FAIL drain_issue i=%0d ov=%b rid=%0d val=%h exp_rid=%0d",
                            i, output_valid, output_rs_id, op_value_out, t);
      end
      advance();
    end
    sample();
    checks++;
    if (occupancy !== 4'd0 || output_valid !== 1'b0) begin
      errors++; $display("FAIL drained occ=%0d ov=%b required 0 0", occupancy, output_valid);
    end
    advance();
  endtask

  task automatic test_age_order();
    idle();
    output_ready      = 1'b1;
    take_valid        = 1'b1;
    op_value_valid_in = 2'b01;
    op_value_in       = {32'd0, 32'd10};
    op_rs_id_in       = {5'd5, 5'd0};
    control_in        = 8'd1;
    sample();
    checks++;
    if (act_b !== exp_b || id_taken !== 5'd0) begin
      errors++; $display("FAIL age_take0 act=%h exp=%h", act_b, exp_b);
    end
    advance();
    op_value_valid_in = 2'b11;
    op_value_in       = {32'd21, 32'd20};
    control_in        = 8'd2;
    sample();
    checks++;
    if (act_b !== exp_b || id_taken !== 5'd1 || output_valid !== 1'b0) begin
      errors++; $display("FAIL age_take1 act=%h exp=%h", act_b, exp_b);
    end
    advance();
    take_valid = 1'b0;
    sample();
    checks++;
    if (act_b !== exp_b || output_valid !== 1'b1 || output_rs_id !== 5'd1) begin
      errors++; $display("FAIL age_young_first ov=%b rid=%0d required 1 1", output_valid, output_rs_id);
    end
    advance();
    update_valid       = 2'b10;
    update_rs_id_in[1] = 5'd5;
    update_value_in[1] = 32'd16;
    sample();
    checks++;
    if (act_b !== exp_b || output_valid !== 1'b0) begin
      errors++; $display("FAIL age_update_cycle ov=%b required 0", output_valid);
    end
    advance();
    update_valid = '0;
    sample();
    checks++;
    if (act_b !== exp_b || output_valid !== 1'b1 || output_rs_id !== 5'd0 || op_value_out !== {32'd16, 32'd10}) begin
      errors++; $display("FAIL age_wakeup ov=%b rid=%0d val=%h", output_valid, output_rs_id, op_value_out);
    end
    advance();
  endtask

  task automatic test_dual_wakeup();
    idle();
    output_ready      = 1'b1;
    take_valid        = 1'b1;
    op_value_valid_in = 2'b00;
    op_rs_id_in       = {5'd5, 5'd4};
    control_in        = 8'd7;
    sample();
    checks++;
    if (act_b !== exp_b) begin
      errors++; $display("FAIL dual_take act=%h exp=%h", act_b, exp_b);
    end
    advance();
    take_valid      = 1'b0;
    update_valid    = 2'b11;
    update_rs_id_in = {5'd5, 5'd4};
    update_value_in = {32'd16, 32'd12};
    sample();
    checks++;
    if (act_b !== exp_b || output_valid !== 1'b0) begin
      errors++; $display("FAIL dual_update_cycle ov=%b required 0", output_valid);
    end
    advance();
    update_valid = '0;
    sample();
    checks++;
    if (act_b !== exp_b || output_valid !== 1'b1 || op_value_out !== {32'd16, 32'd12}) begin
      errors++; $display("FAIL dual_wakeup ov=%b val=%h required 1 {16,12}", output_valid, op_value_out);
    end
    advance();
  endtask

  task automatic test_bypass();
    idle();
    output_ready       = 1'b1;
    take_valid         = 1'b1;
    op_value_valid_in  = 2'b01;
    op_value_in        = {32'd0, 32'd10};
    op_rs_id_in        = {5'd5, 5'd0};
    update_valid       = 2'b01;
    update_rs_id_in[0] = 5'd5;
    update_value_in[0] = 32'd16;
    sample();
    checks++;
    if (act_b !== exp_b || output_valid !== 1'b0) begin
      errors++; $display("FAIL bypass_take act=%h exp=%h", act_b, exp_b);
    end
    advance();
    take_valid   = 1'b0;
    update_valid = '0;
    sample();
    checks++;
    if (act_b !== exp_b || output_valid !== 1'b1 || op_value_out !== {32'd16, 32'd10}) begin
      errors++; $display("FAIL bypass_issue ov=%b val=%h required 1 {16,10}", output_valid, op_value_out);
    end
    advance();
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 3; i++) begin
      take_valid        = 1'b1;
      op_value_valid_in = 2'b10;
      op_value_in       = {32'(50 + i), 32'd0};
      op_rs_id_in       = {5'd0, 5'(20 + i)};
      sample();
      checks++;
      if (act_b !== exp_b) begin
        errors++; $display("FAIL flush_fill i=%0d act=%h exp=%h", i, act_b, exp_b);
      end
      advance();
    end
    flush = 1'b1;
    sample();
    checks++;
    if (act_b !== exp_b || take_ready !== 1'b0 || output_valid !== 1'b0) begin
      errors++; $display("FAIL flush_pulse tr=%b ov=%b required 0 0", take_ready, output_valid);
    end
    advance();
    flush      = 1'b0;
    take_valid = 1'b0;
    sample();
    checks++;
    if (act_b !== exp_b || occupancy !== 4'd0 || id_taken !== 5'd0 || output_valid !== 1'b0) begin
      errors++; $display("FAIL flush_after occ=%0d id=%0d ov=%b required 0 0 0", occupancy, id_taken, output_valid);
    end
    advance();
    update_valid    = 2'b11;
    update_rs_id_in = {5'd21, 5'd20};
    update_value_in = {32'd2, 32'd1};
    output_ready    = 1'b1;
    sample();
    advance();
    update_valid = '0;
    sample();
    checks++;
    if (act_b !== exp_b || output_valid !== 1'b0) begin
      errors++; $display("FAIL flush_stale_update ov=%b required 0", output_valid);
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst               = ($urandom_range(0, 299) == 0);
      flush             = ($urandom_range(0, 39) == 0);
      take_valid        = ($urandom_range(0, 2) != 0);
      op_value_valid_in = 2'($urandom_range(0, 3));
      control_in        = 8'($urandom());
      update_valid      = 2'($urandom_range(0, 3));
      output_ready      = ($urandom_range(0, 3) != 0);
      for (int o = 0; o < 2; o++) begin
        op_rs_id_in[o]     = 5'($urandom_range(0, 9));
        op_value_in[o]     = $urandom();
        update_rs_id_in[o] = 5'($urandom_range(0, 9));
        update_value_in[o] = $urandom();
      end
      sample();
      checks++;
      if (act_b !== exp_b) begin
        errors++; $display("FAIL random c=%0d act=%h exp=%h", c, act_b, exp_b);
      end
      advance();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_fill_drain();
    test_age_order();
    test_dual_wakeup();
    test_bypass();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_port_reservation_station.md
# multi_port_reservation_station

Parametrised reservation station for the out-of-order execution back end. It buffers up to RS_DEPTH decoded instructions per functional unit and captures pending operands from UPDATE_PORTS result broadcast buses in parallel. It issues the oldest entry whose operands are all valid to the attached unit over a ready-valid interface. Relative to the single-update-bus station it adds multi-port wake-up, same-cycle allocation bypass, age-ordered issue, flush, occupancy reporting and issued-tag output.

## Interface
- OPERANDS, 2, source operands per entry
- RS_OFFSET, 0, tag of slot 0; slot i has tag RS_OFFSET+i
- RS_DEPTH, 8, number of slots
- RS_ID_WIDTH, 5, tag width; RS_OFFSET+RS_DEPTH-1 must fit
- UPDATE_PORTS, 2, number of result broadcast buses
- VALUE_WIDTH, 32, operand width
- CONTROL_TYPE, add_sub_decode_t, opaque per-instruction control payload type

- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- take_valid  in  1  new instruction offered
- take_ready  out  1  a free slot exists and flush is low
- op_value_valid_in  in  [0:OPERANDS-1]  operand value present
- op_rs_id_in  in  RS_ID_WIDTH x OPERANDS  producer tag for each operand whose value is absent
- op_value_in  in  VALUE_WIDTH x OPERANDS  operand value
- control_in  in  CONTROL_TYPE  control payload
- id_taken  out  RS_ID_WIDTH  tag assigned on the accepting edge
- update_valid  in  [0:UPDATE_PORTS-1]  broadcast valid, per port
- update_rs_id_in  in  RS_ID_WIDTH x UPDATE_PORTS  producing tag
- update_value_in  in  VALUE_WIDTH x UPDATE_PORTS  result value
- flush  in  1  discard all entries
- output_valid  out  1  an entry is ready to issue
- output_ready  in  1  functional unit accepts
- op_value_out  out  VALUE_WIDTH x OPERANDS  issued operands
- control_out  out  CONTROL_TYPE  issued payload
- output_rs_id  out  RS_ID_WIDTH  tag of the issued entry
- occupancy  out  $clog2(RS_DEPTH+1)  number of occupied slots

## Operation
- **Slot state:**
  - Each slot holds: busy bit, per-operand value plus valid bit plus tag, control payload and an age.
- **Allocation:**
  - id_taken = RS_OFFSET + index of the lowest-indexed free slot.
  - If no slot is free, id_taken holds RS_OFFSET.
  - On take_valid && take_ready the slot is written and becomes busy at the clock edge.
- **Wake-up:**
  - For every busy slot and operand with valid=0, any update port with update_valid high and a matching tag writes its value and sets valid.
  - If several ports match, the lowest-indexed port wins.
  - Operands that are already valid ignore all updates.
- **Allocation bypass:**
  - Applies to an incoming operand with op_value_valid_in=0 whose tag matches an update in the same cycle.
  - That operand is stored as valid with the update value.
- **Issue selection:**
  - A slot is ready when it is busy and all its operands are valid.
  - The oldest ready slot is selected, i.e. the earliest accepted.
  - output_valid = any slot ready.
  - op_value_out, control_out and output_rs_id come from the selected slot; they are driven zero when output_valid=0.
  - The selected slot frees on output_valid && output_ready.
  - Outputs are held stable while output_valid && !output_ready, unless an older entry becomes ready; in that case selection switches.
- **Free-slot reuse:** a slot freed on an edge is allocatable from the next cycle only. take_ready is a function of registered state and flush only.
- **Flush:**
  - While flush is high, take_ready=0 and output_valid=0.
  - At the edge all slots are cleared.
  - Flush overrides take, update and issue in the same cycle.
- **occupancy:** registered count of busy slots.

## Timing
- **Reset values (while rst high):**
  - All slots not busy, occupancy=0, output_valid=0.
  - take_ready=1 (when flush low), id_taken=RS_OFFSET.
  - op_value_out, control_out and output_rs_id are all zero.
- **Reset mid-operation:** all entries are lost immediately; no partial issue occurs.
- **Latency:**
  - Accept with all operands valid → output_valid in the next cycle.
  - Update or bypass → dependent entry ready in the next cycle.
- **Throughput:** one issue and one allocation per cycle, concurrently.
- **No combinational paths:**
  - None from take_valid, update_* or output_ready to output_valid.
  - None from take_valid or output_ready to take_ready.
- **Full:** take_ready=0 while occupancy=RS_DEPTH, even if an issue handshake occurs in that cycle.
- **Empty:** output_valid=0; updates have no effect.

## Test plan
- Reset, then idle with flush=0 → take_ready=1, id_taken=0, occupancy=0, output_valid=0.
- Offer 10 instructions with op_value_in={i,i+1}, both valid, output_ready=0 → id_taken 0..7 accepted, take_ready=0 after the 8th, occupancy=8. Then set output_ready=1 → issues tags 0..7 in order with {0,1}..{7,8}, one per cycle.
- Two entries accepted while output_ready=1:
  - Tag 0 with {10, pending tag 5}, then tag 1 with both operands valid → tag 1 issues first.
  - Update port 1 broadcasts tag 5 = 16 → tag 0 issues next cycle with {10,16}.
- One entry pending on tags 4 and 5; port 0 sends tag 4 = 12 and port 1 sends tag 5 = 16 in the same cycle → next cycle output_valid=1 with {12,16}.
- Take {10, pending tag 5} in the same cycle as update tag 5 = 16 → entry stores 16; output_valid=1 with {10,16} the next cycle.
- Three entries buffered with output_ready=0, pulse flush together with take_valid → take_ready=0 and output_valid=0 during the pulse. Next cycle occupancy=0, no entry accepted, id_taken=0. A later update of those tags leaves output_valid=0.
